fmap_mem_write: RTL and testbench

Parametrised write-side addresser for a CNN layer's output feature-map memory. It accepts a stream of pooled/convolved pixels from the upstream layer and generates write enables and addresses for every pixel of every output channel. It signals completion with a level `done` that clears on the next `start`. It sits between a layer's datapath and its output RAM and replaces the fixed 4x4 single-channel pooling-2 writer.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/wrap_counter.sv | 28 ++
 rtl/fmap_mem_write.sv | 92 +++++++++
 tb/tb_fmap_mem_write.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: feature-map writer states and width helper.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fmap_state_t;

    // $clog2 that never returns zero, so single-value ranges still get a 1-bit port.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a wrap strobe for carry chaining.
module wrap_counter
    import cnn_pkg::*;
#(
    parameter  int unsigned MAX = 1,
    localparam int unsigned W   = clog2_min1(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = inc && (q == W'(MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/fmap_mem_write.sv
// Output feature-map write addresser: walks col/row/chan on each accepted pixel
// and maps the position to a channel-major or channel-interleaved RAM address.
module fmap_mem_write
    import cnn_pkg::*;
#(
    parameter  int unsigned CHANNELS   = 1,
    parameter  int unsigned DIM        = 4,
    parameter  int unsigned INTERLEAVE = 0,
    parameter  int unsigned ADDR_W     = $clog2(CHANNELS * DIM * DIM),
    localparam int unsigned CW         = clog2_min1(CHANNELS),
    localparam int unsigned RW         = $clog2(DIM)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CW-1:0]     chan,
    output logic [RW-1:0]     row,
    output logic [RW-1:0]     col,
    output logic              busy,
    output logic              done
);

    fmap_state_t state, state_nxt;
    logic        cnt_clr;
    logic        col_wrap, row_wrap, chan_wrap;
    logic [ADDR_W-1:0] pix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake; chan_wrap marks the final pixel of the pass.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        in_ready  = (state == RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
        wr_en     = in_valid && (state == RUN);
        if (clear) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end
                RUN:  if (chan_wrap) state_nxt = DONE;
                DONE: if (start) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    wrap_counter #(.MAX(DIM - 1)) u_col (
        .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(wr_en),
        .q(col), .wrap(col_wrap)
    );

    wrap_counter #(.MAX(DIM - 1)) u_row (
        .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(col_wrap),
        .q(row), .wrap(row_wrap)
    );

    wrap_counter #(.MAX(CHANNELS - 1)) u_chan (
        .clk(clk), .reset_n(reset_n), .clr(cnt_clr), .inc(row_wrap),
        .q(chan), .wrap(chan_wrap)
    );

    always_comb begin
        pix = ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
        if (INTERLEAVE == 0) begin
            wr_addr = ADDR_W'(chan) * ADDR_W'(DIM * DIM) + pix;
        end else begin
            wr_addr = pix * ADDR_W'(CHANNELS) + ADDR_W'(chan);
        end
    end

endmodule

// File: tb/tb_fmap_mem_write.sv
// Directed bench for fmap_mem_write: three configurations, expected write
// addresses queued at stimulus time and checked as each wr_en appears.
module tb_fmap_mem_write;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int q0[$];
    int q1[$];
    int q2[$];

    // DUT A: default 1 channel, 4x4, channel-major
    logic       start0, clear0, in_valid0, in_ready0, wr_en0, busy0, done0;
    logic [3:0] wr_addr0;
    logic [0:0] chan0;
    logic [1:0] row0, col0;

    // DUT B: 3 channels, 2x2, interleaved
    logic       start1, clear1, in_valid1, in_ready1, wr_en1, busy1, done1;
    logic [3:0] wr_addr1;
    logic [1:0] chan1;
    logic [0:0] row1, col1;

    // DUT C: 2 channels, 3x3, channel-major
    logic       start2, clear2, in_valid2, in_ready2, wr_en2, busy2, done2;
    logic [4:0] wr_addr2;
    logic [0:0] chan2;
    logic [1:0] row2, col2;

    fmap_mem_write u_a (
        .clk(clk), .reset_n(reset_n), .start(start0), .clear(clear0),
        .in_valid(in_valid0), .in_ready(in_ready0), .wr_en(wr_en0),
        .wr_addr(wr_addr0), .chan(chan0), .row(row0), .col(col0),
        .busy(busy0), .done(done0)
    );

    fmap_mem_write #(.CHANNELS(3), .DIM(2), .INTERLEAVE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start1), .clear(clear1),
        .in_valid(in_valid1), .in_ready(in_ready1), .wr_en(wr_en1),
        .wr_addr(wr_addr1), .chan(chan1), .row(row1), .col(col1),
        .busy(busy1), .done(done1)
    );

    fmap_mem_write #(.CHANNELS(2), .DIM(3), .INTERLEAVE(0)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start2), .clear(clear2),
        .in_valid(in_valid2), .in_ready(in_ready2), .wr_en(wr_en2),
        .wr_addr(wr_addr2), .chan(chan2), .row(row2), .col(col2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every write must match the next queued address; no extra writes.
    always @(negedge clk) begin
        if (wr_en0) begin
            if (q0.size() == 0) chk("a_unexpected_write", 32'(wr_addr0), 32'hffff_ffff);
            else                chk("a_wr_addr", 32'(wr_addr0), 32'(q0.pop_front()));
        end
        if (wr_en1) begin
            if (q1.size() == 0) chk("b_unexpected_write", 32'(wr_addr1), 32'hffff_ffff);
            else                chk("b_wr_addr", 32'(wr_addr1), 32'(q1.pop_front()));
        end
        if (wr_en2) begin
            if (q2.size() == 0) chk("c_unexpected_write", 32'(wr_addr2), 32'hffff_ffff);
            else                chk("c_wr_addr", 32'(wr_addr2), 32'(q2.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b0;
        {start0, clear0, in_valid0} = '0;
        {start1, clear1, in_valid1} = '0;
        {start2, clear2, in_valid2} = '0;
        cyc(2);
        chk("rst_wr_addr", 32'(wr_addr0), 0);
        chk("rst_busy_done_ready", {busy0, done0, in_ready0, wr_en0}, 0);
        chk("rst_counters", {chan0, row0, col0}, 0);
        reset_n = 1'b1;

        // idle pulses on in_valid must not write
        in_valid0 = 1'b1;
        cyc(2);

        // pass 1: 16 consecutive writes
        for (int i = 0; i < 16; i++) q0.push_back(i);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        chk("a_busy_after_start", {busy0, in_ready0, done0}, 3'b110);
        chk("a_first_addr", 32'(wr_addr0), 0);
        cyc(16);
        chk("a_done_after_last", {done0, busy0, in_ready0, wr_en0}, 4'b1000);
        cyc(3);
        chk("a_done_holds", 32'(done0), 1);
        chk("a_pass1_drained", q0.size(), 0);

        // pass 2 from DONE
        for (int i = 0; i < 16; i++) q0.push_back(i);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        chk("a_done_drops", {done0, busy0}, 2'b01);
        chk("a_restart_addr", 32'(wr_addr0), 0);
        cyc(16);
        chk("a_pass2_done", 32'(done0), 1);
        chk("a_pass2_drained", q0.size(), 0);

        // async reset after 7 writes
        for (int i = 0; i < 7; i++) q0.push_back(i);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(7);
        chk("a_addr_before_reset", 32'(wr_addr0), 7);
        reset_n = 1'b0;
        #1;
        chk("a_reset_outputs", {busy0, done0, in_ready0, wr_en0}, 0);
        chk("a_reset_addr", 32'(wr_addr0), 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("a_idle_after_reset", {busy0, done0}, 0);
        for (int i = 0; i < 16; i++) q0.push_back(i);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(16);
        chk("a_pass3_done", 32'(done0), 1);
        chk("a_pass3_drained", q0.size(), 0);

        // start ignored in RUN, then clear+start aborts
        for (int i = 0; i < 9; i++) q0.push_back(i);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        cyc(5);
        start0 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        chk("a_start_ignored_addr", 32'(wr_addr0), 6);
        chk("a_start_ignored_busy", 32'(busy0), 1);
        cyc(2);
        clear0 = 1'b1;
        start0 = 1'b1;
        cyc(1);
        clear0 = 1'b0;
        start0 = 1'b0;
        chk("a_clear_state", {busy0, done0, in_ready0}, 0);
        chk("a_clear_counters", {chan0, row0, col0}, 0);
        chk("a_clear_addr", 32'(wr_addr0), 0);
        cyc(3);
        chk("a_clear_drained", q0.size(), 0);
        in_valid0 = 1'b0;

        // DUT B: interleaved mapping
        q1 = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
        start1    = 1'b1;
        in_valid1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        cyc(11);
        chk("b_not_done_before_last", {done1, busy1}, 2'b01);
        cyc(1);
        chk("b_done", {done1, busy1}, 2'b10);
        cyc(2);
        chk("b_drained", q1.size(), 0);
        in_valid1 = 1'b0;

        // DUT C: toggling valid, 18 writes over 36 cycles
        for (int i = 0; i < 18; i++) q2.push_back(i);
        start2    = 1'b1;
        in_valid2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        for (int i = 0; i < 36; i++) begin
            in_valid2 = (i % 2 == 0);
            cyc(1);
        end
        chk("c_done", {done2, busy2}, 2'b10);
        chk("c_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
